// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - shared constants and types for the sprite ROM arbiter
package sprite_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  // Requester slots on the shared sprite ROM port
  localparam req_id_t REQ_PLAYER        = req_id_t'(0);
  localparam req_id_t REQ_PERSON_A      = req_id_t'(1);
  localparam req_id_t REQ_PERSON_A_DEAD = req_id_t'(2);
  localparam req_id_t REQ_POLICE_CAR    = req_id_t'(3);

  // Tag travelling alongside a ROM read until its data returns
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker (rotate, priority-encode, rotate back)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] k;
  logic [IW:0]   sum;

  // Rotate so the pointer position lands at bit 0
  assign rot = N'({req_i, req_i} >> ptr_i);

  // Lowest set rotated bit wins; map its offset back to an absolute index
  always_comb begin
    any_o = 1'b0;
    k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any_o = 1'b1;
        k     = IW'(i);
      end
    end
    sum = {1'b0, k} + {1'b0, ptr_i};
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    idx_o = sum[IW-1:0];
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sharing of the sprite ROM port; SPRITE_ARB_FIXED_PRIO_EN gives the player absolute priority
import sprite_arb_pkg::*;

module sprite_rom_arbiter #(
  parameter int NUM_REQ = sprite_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data
);

  localparam int IW = $clog2(NUM_REQ);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_w_t;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [IW-1:0]      iss_id_q, iss_id_d;
  tag_w_t             tag_q [ROM_LAT];
  tag_w_t             tag_d [ROM_LAT];

  logic [NUM_REQ-1:0] pick_req, pick_gnt, win_gnt;
  logic [IW-1:0]      pick_idx, win_idx, nxt_ptr;
  logic               pick_any, win_any;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  // The player never competes in the rotation; it overrides it below
  assign pick_req = req & ~NUM_REQ'(1);
`else
  assign pick_req = req;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (pick_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Final winner selection, suppressed entirely while in reset
  always_comb begin
    win_gnt = '0;
    win_idx = '0;
    win_any = 1'b0;
    if (Reset_n) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      if (req[REQ_PLAYER]) begin
        win_any = 1'b1;
        win_idx = IW'(REQ_PLAYER);
        win_gnt = NUM_REQ'(1);
      end else begin
        win_any = pick_any;
        win_idx = pick_idx;
        win_gnt = pick_gnt;
      end
`else
      win_any = pick_any;
      win_idx = pick_idx;
      win_gnt = pick_gnt;
`endif
    end
  end

  assign gnt = win_gnt;

  // Next pointer, issue registers and tag shift
  always_comb begin
    ptr_d      = ptr_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    iss_id_d   = '0;
    nxt_ptr    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    if (win_any) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = req_addr[win_idx*ADDR_W +: ADDR_W];
      iss_id_d   = win_idx;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      // Player grants leave the rotation untouched; pointer skips slot 0
      if (win_idx != IW'(REQ_PLAYER)) begin
        ptr_d = (nxt_ptr == '0) ? IW'(1) : nxt_ptr;
      end
`else
      ptr_d = nxt_ptr;
`endif
    end
    tag_d[0] = '{valid: mem_rd_q, id: iss_id_q};
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // State registers; reset drops any read still in flight
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      iss_id_q   <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      iss_id_q   <= iss_id_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = tag_q[ROM_LAT-1].valid;
  assign rsp_id    = tag_q[ROM_LAT-1].id;
  assign rsp_data  = mem_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 5;
  localparam int LAT = 1;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      gnt;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;

  sprite_rom_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (LAT)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] rom_f(logic [AW-1:0] a);
    return a[4:0] ^ a[12:8];
  endfunction

  // ROM stand-in with LAT cycles of read latency
  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge Clk) begin
    rom_pipe[0] <= mem_rd ? rom_f(mem_addr) : '0;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign mem_data = rom_pipe[LAT-1];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            glog[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            m_ptr = 0;
  logic          exp_rd = 1'b0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_pick(logic [N-1:0] r, int p);
    int j;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    if (r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (j != 0 && r[j]) return j;
    end
`else
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j]) return j;
    end
`endif
    return -1;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    int   w;
    int   expg;
    exp_t e;
    logic [AW-1:0] a;
    check("mem_rd", mem_rd, exp_rd);
    check("mem_addr", mem_addr, exp_addr);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, e.id);
      check("rsp_data", rsp_data, e.data);
    end else begin
      check("rsp_valid_idle", rsp_valid, 0);
    end
    w    = Reset_n ? model_pick(req, m_ptr) : -1;
    expg = (w >= 0) ? (1 << w) : 0;
    check("gnt", gnt, expg);
    for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
    if (!Reset_n) begin
      m_ptr    = 0;
      exp_rd   = 1'b0;
      exp_addr = '0;
      sb.delete();
    end else if (w >= 0) begin
      a        = req_addr[w*AW +: AW];
      exp_rd   = 1'b1;
      exp_addr = a;
      sb.push_back('{due: cyc + 1 + LAT, id: w, data: rom_f(a)});
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      if (w != 0) begin
        m_ptr = (w + 1) % N;
        if (m_ptr == 0) m_ptr = 1;
      end
`else
      m_ptr = (w + 1) % N;
`endif
    end else begin
      exp_rd = 1'b0;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_addr(int i, logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic check_log(string tag, int exp_ids[$]);
    check({tag, "_len"}, glog.size(), exp_ids.size());
    for (int k = 0; k < exp_ids.size(); k++) begin
      check(tag, (k < glog.size()) ? glog[k] : -1, exp_ids[k]);
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    repeat (3) tick();
    check("rst_rsp_id", rsp_id, 0);
    check("rst_mem_addr", mem_addr, 0);
    Reset_n = 1'b1;
    tick();

`ifndef SPRITE_ARB_FIXED_PRIO_EN
    // single request from requester 1
    glog.delete();
    set_addr(1, 16'h0123);
    req = 4'b0010;
    tick();
    req = '0;
    repeat (4) tick();
    check_log("single", '{1});

    // all four from reset
    Reset_n = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    set_addr(0, 16'h1a2b);
    set_addr(1, 16'h0c3d);
    set_addr(2, 16'h1f07);
    set_addr(3, 16'h0916);
    glog.delete();
    req = 4'b1111;
    repeat (8) tick();
    req = '0;
    repeat (3) tick();
    check_log("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});

    // pointer wrap after requester 3
    glog.delete();
    req = 4'b0101;
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (3) tick();
    check_log("wrap", '{0, 2});

    // requester 2 gives up before its turn
    glog.delete();
    set_addr(2, 16'h0777);
    req = 4'b1111;
    tick();
    req = 4'b0111;
    tick();
    req = 4'b0110;
    tick();
    req = '0;
    repeat (3) tick();
    check_log("drop", '{3, 0, 1});

    // reset right after a grant
    req = 4'b0010;
    tick();
    Reset_n = 1'b0;
    req     = 4'b1000;
    repeat (2) tick();
    Reset_n = 1'b1;
    glog.delete();
    req = 4'b1001;
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    repeat (3) tick();
    check_log("post_rst", '{0, 3});
`else
    // player dominates, then the rest rotate
    set_addr(0, 16'h0040);
    set_addr(1, 16'h0551);
    set_addr(2, 16'h0a62);
    set_addr(3, 16'h1f73);
    glog.delete();
    req = 4'b1111;
    repeat (4) tick();
    req = 4'b1110;
    repeat (4) tick();
    req = '0;
    repeat (3) tick();
    check_log("prio", '{0, 0, 0, 0, 1, 2, 3, 1});
`endif

    repeat (4) tick();
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
